probe_serializer: RTL and testbench

PROBE_SERIALIZER -- requirements
Module: probe_serializer

---
 rtl/probe_serializer.sv | 154 +++++++++++++++
 tb/tb_probe_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/probe_serializer.sv
// Probe word serializer: captures one of CH probe words and hands it out LSB byte first.
// Optional PROBE_CHECKSUM_EN appends an XOR checksum byte after the data bytes.
module probe_serializer #(
    parameter int unsigned CH = 2,
    parameter int unsigned W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [CH*W-1:0] probe_i,
    input  logic [3:0]      sel_i,
    input  logic            cap_i,
    input  logic            nxt_i,
    output logic [7:0]      byte_o,
    output logic            vld_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            sel_err_o
);

    localparam int unsigned NB   = W / 8;
    localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;

`ifdef PROBE_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StSend, StChk} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [W-1:0]      shadow_q, shadow_d;
    logic [7:0]        byte_q, byte_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic              sel_err_q, sel_err_d;

    logic [W-1:0]      sel_word;
    logic              sel_bad;
    logic [IdxW-1:0]   idx_inc;
    logic [7:0]        next_byte;

    // Out-of-range selects capture an all-zero word rather than wrapping.
    always_comb begin
        sel_bad  = (32'(sel_i) >= CH);
        sel_word = '0;
        for (int c = 0; c < int'(CH); c++) begin
            if (32'(sel_i) == 32'(c)) begin
                sel_word = probe_i[c*W +: W];
            end
        end
    end

    always_comb begin
        idx_inc   = idx_q + 1'b1;
        next_byte = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (idx_inc == IdxW'(i)) begin
                next_byte = shadow_q[i*8 +: 8];
            end
        end
    end

`ifdef PROBE_CHECKSUM_EN
    logic [7:0] chk_byte;

    always_comb begin
        chk_byte = '0;
        for (int i = 0; i < int'(NB); i++) begin
            chk_byte = chk_byte ^ shadow_q[i*8 +: 8];
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        byte_d    = byte_q;
        vld_d     = vld_q;
        done_d    = 1'b0;
        sel_err_d = sel_err_q;

        if (ena) begin
            unique case (state_q)
                StIdle: begin
                    // nxt_i is deliberately not looked at here.
                    if (cap_i) begin
                        shadow_d  = sel_word;
                        idx_d     = '0;
                        byte_d    = sel_word[7:0];
                        vld_d     = 1'b1;
                        sel_err_d = sel_bad;
                        state_d   = StSend;
                    end
                end
                StSend: begin
                    if (nxt_i) begin
                        if (idx_q != IdxW'(NB - 1)) begin
                            idx_d  = idx_inc;
                            byte_d = next_byte;
                        end else begin
`ifdef PROBE_CHECKSUM_EN
                            byte_d  = chk_byte;
                            state_d = StChk;
`else
                            vld_d   = 1'b0;
                            done_d  = 1'b1;
                            state_d = StIdle;
`endif
                        end
                    end
                end
`ifdef PROBE_CHECKSUM_EN
                StChk: begin
                    if (nxt_i) begin
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            shadow_q  <= '0;
            byte_q    <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            byte_q    <= byte_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign byte_o    = byte_q;
    assign vld_o     = vld_q;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_probe_serializer.sv
// Directed bench for probe_serializer (CH=2, W=32); expected bytes are queued at capture
// and popped as the serializer presents them.
module tb_probe_serializer;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 32;

    logic            clk;
    logic            rst_n;
    logic            ena;
    logic [CH*W-1:0] probe_i;
    logic [3:0]      sel_i;
    logic            cap_i;
    logic            nxt_i;
    logic [7:0]      byte_o;
    logic            vld_o;
    logic            busy_o;
    logic            done_o;
    logic            sel_err_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    probe_serializer #(.CH(CH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .probe_i   (probe_i),
        .sel_i     (sel_i),
        .cap_i     (cap_i),
        .nxt_i     (nxt_i),
        .byte_o    (byte_o),
        .vld_o     (vld_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .sel_err_o (sel_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the bytes a transaction of this word should produce.
    task automatic push_word(input logic [31:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[i*8 +: 8]);
            x = x ^ w[i*8 +: 8];
        end
`ifdef PROBE_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic capture(input string tag, input logic [3:0] s, input logic [31:0] w,
                           input logic exp_err);
        sel_i = s;
        cap_i = 1'b1;
        tick();
        cap_i = 1'b0;
        push_word(w);
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        chk({tag, "_selerr"}, 32'(sel_err_o), 32'(exp_err));
    endtask

    // Consume one byte: compare, then acknowledge it.
    task automatic take(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        chk({tag, "_vld"}, 32'(vld_o), 32'd1);
        chk({tag, "_byte"}, 32'(byte_o), 32'(e));
        chk({tag, "_done_early"}, 32'(done_o), 32'd0);
        nxt_i = 1'b1;
        tick();
        nxt_i = 1'b0;
    endtask

    task automatic send_all(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 16) begin
            take(tag);
            guard++;
        end
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_vld_end"}, 32'(vld_o), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        probe_i = {32'hDEADBEEF, 32'h12345678};
        sel_i   = 4'd0;
        cap_i   = 1'b0;
        nxt_i   = 1'b0;
        #2;
        chk("rst_byte", 32'(byte_o), 32'h0);
        chk("rst_vld", 32'(vld_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_selerr", 32'(sel_err_o), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        // Basic channel 0 transaction.
        capture("ch0", 4'd0, 32'h12345678, 1'b0);
        send_all("ch0");

        // Channel 1, probe input cleared right after capture.
        capture("ch1", 4'd1, 32'hDEADBEEF, 1'b0);
        probe_i = '0;
        send_all("ch1");
        probe_i = {32'hDEADBEEF, 32'h12345678};

        // Out-of-range select yields zeros and a sticky error flag.
        capture("bad", 4'd5, 32'h0, 1'b1);
        send_all("bad");
        chk("bad_selerr_held", 32'(sel_err_o), 32'd1);
        capture("clr", 4'd0, 32'h12345678, 1'b0);
        send_all("clr");

        // Stall on byte 1 with a spurious capture, then a disabled stretch.
        capture("stall", 4'd0, 32'h12345678, 1'b0);
        take("stall_b0");
        probe_i = '0;
        for (int i = 0; i < 10; i++) begin
            cap_i = (i == 4);
            sel_i = 4'd1;
            tick();
            chk("stall_hold_byte", 32'(byte_o), 32'(exp_q[0]));
            chk("stall_hold_vld", 32'(vld_o), 32'd1);
        end
        cap_i = 1'b0;
        ena   = 1'b0;
        nxt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ena_hold_byte", 32'(byte_o), 32'(exp_q[0]));
            chk("ena_hold_done", 32'(done_o), 32'd0);
        end
        nxt_i   = 1'b0;
        ena     = 1'b1;
        probe_i = {32'hDEADBEEF, 32'h12345678};
        send_all("stall");

        // Asynchronous reset mid-transaction.
        capture("arst", 4'd0, 32'h12345678, 1'b0);
        take("arst_b0");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_byte", 32'(byte_o), 32'h0);
        chk("arst_vld", 32'(vld_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        chk("arst_no_done", 32'(done_o), 32'd0);
        capture("rest", 4'd0, 32'h12345678, 1'b0);
        send_all("rest");

        // cap_i and nxt_i together in IDLE: the first byte must not be skipped.
        sel_i = 4'd0;
        cap_i = 1'b1;
        nxt_i = 1'b1;
        tick();
        cap_i = 1'b0;
        nxt_i = 1'b0;
        push_word(32'h12345678);
        chk("both_b0", 32'(byte_o), 32'h78);
        tick();
        chk("both_b0_hold", 32'(byte_o), 32'h78);
        send_all("both");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
